fpadd_acc_seq: RTL and testbench
================================

Name: fpadd_acc_seq

Overview:
- Sequential initiator that drives the combinational single-precision adder: it issues `a`/`b`/`control` operands and captures `result`/`flags` back.
- Accumulates a frame of NTAPS FP samples, such as FIR tap products, into a running sum.
- Presents the final sum with OR-accumulated exception flags on a valid/ready output.
- Sits between the multiplier/product stream and the FIR output stage.

Parameters:
- WIDTH, 32, FP word width (sign, 8-bit exponent, 23-bit fraction).
- WCONTROL, 5, adder control width: bit4 op, bit3 overtrap, bit2 undertrap, bits1:0 roundmode.
- WFLAG, 5, adder exception-flag vector width.
- NTAPS, 16, samples per frame; legal range is 1 to 2^WCNT-1.
- WCNT, 5, tap counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begins a frame; sampled only in IDLE.
- roundmode  in  2  rounding mode; latched at start.
- trap_en  in  2  {overtrap, undertrap}; latched at start.
- in_valid  in  1  sample valid.
- in_data  in  WIDTH  FP sample.
- in_sub  in  1  1 = subtract this sample from the accumulator, 0 = add.
- in_ready  out  1  accumulator ready for a sample.
- add_a  out  WIDTH  adder operand a (accumulator).
- add_b  out  WIDTH  adder operand b (in_data).
- add_control  out  WCONTROL  adder control word.
- add_result  in  WIDTH  adder sum, combinational from add_a/add_b/add_control.
- add_flags  in  WFLAG  adder exception flags, combinational.
- out_valid  out  1  frame result valid.
- out_data  out  WIDTH  frame sum.
- out_flags  out  WFLAG  OR of all adder flags over the frame.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - acc = 32'h00000000 (+0.0), cnt = 0, flag_acc = 0.
  - Latched roundmode and trap fields = 0.
  - Outputs: in_ready = 0, out_valid = 0, out_data = 0, out_flags = 0, busy = 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On start = 1: clear acc to +0.0, cnt = 0, flag_acc = 0; latch roundmode and trap_en; go to ACCUM.
  - in_ready is high on the next cycle.
- Operand issue (combinational):
  - add_a = acc, add_b = in_data.
  - add_control = {in_sub, trap_en[1], trap_en[0], roundmode_latched}.
  - These drive the adder in every state; the block ignores add_result outside accepted transfers.
- ACCUM:
  - in_ready = 1.
  - A transfer occurs when in_valid && in_ready. On the same edge: acc <= add_result, flag_acc <= flag_acc | add_flags, cnt <= cnt + 1.
  - Single-cycle issue-to-capture; no pipeline bubbles. One sample per cycle is sustainable.
  - in_valid low: no state change; acc holds.
  - When a transfer makes cnt+1 == NTAPS, go to DONE.
  - On that edge, register out_data <= add_result and out_flags <= flag_acc | add_flags.
- DONE:
  - out_valid = 1, in_ready = 0.
  - out_data and out_flags are held stable while out_ready = 0.
  - When out_valid && out_ready: out_valid drops on the next edge and state returns to IDLE.
  - out_data and out_flags keep their last value after the handshake.
- start outside IDLE is ignored. start asserted in the same cycle as the DONE handshake is also ignored; a new frame requires start in IDLE.
- Latency:
  - Start accepted at edge t; first sample accepted at edge t+1 at the earliest.
  - Final sample at edge t; out_valid is high after edge t.
  - Minimum frame length is NTAPS+2 cycles including the return to IDLE.
- Special values (NaN, infinity, overflow) pass through the adder unmodified and stay in acc. Flags are sticky for the whole frame.
- Reset mid-frame aborts the frame; no partial result is emitted.

Test Plan:
- NTAPS=4, RN; samples 3F800000, 40000000, 3F000000, 3F000000 (1.0, 2.0, 0.5, 0.5), all in_sub=0, back-to-back -> out_data=40800000 (4.0), out_flags=0, out_valid one cycle after the 4th accept.
- Same samples with in_valid toggling every other cycle -> identical result; acc unchanged on idle cycles; cnt reaches 4 only after 4 accepts.
- NTAPS=2; samples 40400000 (add), 3F800000 with in_sub=1 -> out_data=40000000 (2.0).
- NTAPS=2, no traps; 7F7FFFFF + 7F7FFFFF -> out_data=7F800000, overflow and inexact bits set in out_flags.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data, out_flags stable; start pulses ignored; busy=1 throughout.
- Assert reset after 2 of 4 samples -> all outputs 0 and state IDLE immediately. A new start then yields a correct fresh sum with no carry-over from the aborted frame.

Source files
------------

// File: rtl/fpadd_acc_seq.sv
// -----------------------------------------------------------------------------
// fpadd_acc_seq
//
// Frame accumulator built around an external combinational single-precision
// adder. A frame begins with a start pulse in IDLE, then takes NTAPS samples.
// Each accepted sample is added to (or subtracted from) the running sum in the
// same cycle. The finished sum is presented with the OR of every adder flag
// raised during the frame.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   start          begin a frame (sampled only in IDLE)
//   roundmode      rounding mode, latched at start
//   trap_en        {overtrap, undertrap}, latched at start
//   in_valid/in_ready/in_data/in_sub   sample stream (in_sub=1 subtracts)
//   add_a/add_b/add_control            operands issued to the adder
//   add_result/add_flags               adder response, combinational
//   out_valid/out_ready/out_data/out_flags   frame result
//   busy           high whenever the FSM is not in IDLE
//   dbg_state      current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until that edge. out_data and
// out_flags stay constant while out_valid is high.
// -----------------------------------------------------------------------------
module fpadd_acc_seq #(
    parameter int WIDTH    = 32,
    parameter int WCONTROL = 5,
    parameter int WFLAG    = 5,
    parameter int NTAPS    = 16,
    parameter int WCNT     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          roundmode,
    input  logic [1:0]          trap_en,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_sub,
    output logic                in_ready,
    output logic [WIDTH-1:0]    add_a,
    output logic [WIDTH-1:0]    add_b,
    output logic [WCONTROL-1:0] add_control,
    input  logic [WIDTH-1:0]    add_result,
    input  logic [WFLAG-1:0]    add_flags,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [WFLAG-1:0]    out_flags,
    input  logic                out_ready,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_acc;
    logic [WCNT-1:0]    r_cnt;
    logic [WFLAG-1:0]   r_flag_acc;
    logic [1:0]         r_rm;
    logic [1:0]         r_trap;
    logic [WIDTH-1:0]   r_out_data;
    logic [WFLAG-1:0]   r_out_flags;

    logic               w_start_ok;
    logic               w_xfer;
    logic               w_last;

    // The adder is driven continuously; its response only matters on a transfer.
    assign add_a       = r_acc;
    assign add_b       = in_data;
    assign add_control = {in_sub, r_trap, r_rm};

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_xfer     = in_valid && in_ready;
    // The sample that closes the frame is the one taken while cnt == NTAPS-1.
    assign w_last     = w_xfer && (r_cnt == WCNT'(NTAPS - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_next_state = S_ACCUM;
            S_ACCUM: if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_flag_acc  <= '0;
            r_rm        <= '0;
            r_trap      <= '0;
            r_out_data  <= '0;
            r_out_flags <= '0;
        end else if (w_start_ok) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_flag_acc <= '0;
            r_rm       <= roundmode;
            r_trap     <= trap_en;
        end else if (w_xfer) begin
            r_acc      <= add_result;
            r_flag_acc <= r_flag_acc | add_flags;
            r_cnt      <= r_cnt + 1'b1;
            // Capture straight from the adder so the result is ready one cycle
            // after the final sample, without waiting for r_acc to update.
            if (w_last) begin
                r_out_data  <= add_result;
                r_out_flags <= r_flag_acc | add_flags;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_acc_seq.sv
module tb_fpadd_acc_seq;

  localparam int NT = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  roundmode;
  logic [1:0]  trap_en;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sub;
  logic        in_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [4:0]  add_control;
  logic [31:0] add_result;
  logic [4:0]  add_flags;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_flags;
  logic        out_ready;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];   // {flags, data}

  logic [31:0] f_smp[NT];
  logic        f_sub[NT];

  fpadd_acc_seq #(.WIDTH(32), .WCONTROL(5), .WFLAG(5), .NTAPS(NT), .WCNT(5)) dut (
    .clk(clk), .reset(reset), .start(start), .roundmode(roundmode), .trap_en(trap_en),
    .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_control(add_control),
    .add_result(add_result), .add_flags(add_flags),
    .out_valid(out_valid), .out_data(out_data), .out_flags(out_flags),
    .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- adder environment model (round to nearest) ----------------
  // flags: bit0 inexact, bit1 underflow, bit2 overflow, bit3 div-by-zero, bit4 invalid
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) m = real'(b[22:0]) * (2.0 ** (-149));
    else        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic void r2f(input real x, output logic [31:0] bits, output logic [4:0] fl);
    real    ax, sc, frc;
    longint m;
    int     be;
    logic   s;
    fl = '0;
    s  = (x < 0.0);
    ax = s ? -x : x;
    if (ax == 0.0) begin
      bits = {s, 31'd0};
      return;
    end
    be = 127;
    while (ax >= 2.0) begin ax = ax / 2.0; be++; end
    while (ax < 1.0 && be > 1) begin ax = ax * 2.0; be--; end
    sc  = ax * 8388608.0;
    m   = longint'($floor(sc));
    frc = sc - real'(m);
    if (frc > 0.5 || (frc == 0.5 && m[0])) m++;
    if (frc != 0.0) fl[0] = 1'b1;
    if (ax < 1.0) begin
      bits = {s, 31'(m)};
      if (fl[0]) fl[1] = 1'b1;
    end else begin
      if (m == 64'd16777216) begin m = 64'd8388608; be++; end
      if (be >= 255) begin
        bits  = {s, 8'hFF, 23'd0};
        fl[2] = 1'b1;
        fl[0] = 1'b1;
      end else begin
        bits = {s, 8'(be), 23'(m - 64'd8388608)};
      end
    end
  endfunction

  function automatic void fp_add(input logic [31:0] a, input logic [31:0] b, input logic [4:0] ctl,
                                 output logic [31:0] r, output logic [4:0] fl);
    logic [31:0] bb;
    logic na, nb, ia, ib;
    bb = {b[31] ^ ctl[4], b[30:0]};
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
    fl = '0;
    if (na || nb)                        r = 32'h7FC00000;
    else if (ia && ib && a[31] != bb[31]) begin r = 32'h7FC00000; fl = 5'b10000; end
    else if (ia)                         r = a;
    else if (ib)                         r = bb;
    else                                 r2f(f2r(a) + f2r(bb), r, fl);
  endfunction

  always @(add_a or add_b or add_control) fp_add(add_a, add_b, add_control, add_result, add_flags);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %h/%h with empty queue", out_data, out_flags);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("frame_data", 64'(out_data), 64'(e[31:0]));
        check("frame_flags", 64'(out_flags), 64'(e[36:32]));
      end
    end
  end

  // ---------------- driver ----------------
  // use_const: push the given constant expectation instead of the model result.
  task automatic run_frame(input logic [1:0] rm, input logic [1:0] tr, input int gmin, input int gmax,
                           input int stall, input bit use_const, input logic [31:0] c_data,
                           input logic [4:0] c_flags);
    logic [31:0] acc, r;
    logic [4:0]  fl, f;
    int          to;
    // whole-frame reference: running sum of +/- samples starting from +0.0
    acc = 32'h0;
    fl  = '0;
    for (int i = 0; i < NT; i++) begin
      fp_add(acc, f_smp[i], {f_sub[i], tr, rm}, r, f);
      acc = r;
      fl  = fl | f;
    end
    if (use_const) exp_q.push_back({c_flags, c_data});
    else           exp_q.push_back({fl, acc});

    roundmode = rm;
    trap_en   = tr;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    roundmode = 2'($urandom);   // latched copy must be used from here on
    trap_en   = 2'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));

    acc = 32'h0;
    fl  = '0;
    for (int i = 0; i < NT; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_sub   = 1'($urandom);
        #1;
        check("acc_hold", 64'(add_a), 64'(acc));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = f_smp[i];
      in_sub   = f_sub[i];
      #1;
      to = 0;
      while (!in_ready && to < 50) begin @(posedge clk); #1; to++; end
      if (to >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0, expected 1");
      end
      check("add_a", 64'(add_a), 64'(acc));
      check("add_control", 64'(add_control), 64'({f_sub[i], tr, rm}));
      fp_add(acc, f_smp[i], {f_sub[i], tr, rm}, r, f);
      acc = r;
      fl  = fl | f;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("out_valid_after_last", 64'(out_valid), 64'(1));
    check("in_ready_in_done", 64'(in_ready), 64'(0));

    out_ready = 1'b0;
    repeat (stall) begin
      start = 1'($urandom);
      #1;
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_busy", 64'(busy), 64'(1));
      check("stall_data", 64'(out_data), 64'(acc));
      check("stall_flags", 64'(out_flags), 64'(fl));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    start     = 1'b1;   // coincides with the handshake, must be ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_dropped", 64'(out_valid), 64'(0));
    check("state_idle", 64'(dbg_state), 64'(0));
    check("data_kept", 64'(out_data), 64'(acc));
    @(posedge clk); #1;
    check("start_ignored_busy", 64'(busy), 64'(0));
  endtask

  task automatic load(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] s3, input logic [3:0] sub);
    f_smp[0] = s0; f_smp[1] = s1; f_smp[2] = s2; f_smp[3] = s3;
    for (int i = 0; i < NT; i++) f_sub[i] = sub[i];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int to;
    reset = 1'b1; start = 1'b0; roundmode = '0; trap_en = '0;
    in_valid = 1'b0; in_data = '0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_flags", 64'(out_flags), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_add_a", 64'(add_a), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 1.0 + 2.0 + 0.5 + 0.5 back-to-back
    load(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000);
    run_frame(2'b00, 2'b00, 0, 0, 0, 1, 32'h40800000, 5'b0);
    // same samples, one idle cycle between each
    run_frame(2'b00, 2'b00, 1, 1, 0, 1, 32'h40800000, 5'b0);
    // 3.0 - 1.0 (padded with +0.0)
    load(32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000, 4'b0010);
    run_frame(2'b00, 2'b00, 0, 0, 0, 1, 32'h40000000, 5'b0);
    // overflow to +inf: overflow and inexact stick
    load(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, 4'b0000);
    run_frame(2'b00, 2'b00, 0, 0, 0, 1, 32'h7F800000, 5'b00101);
    // consumer stalls for 5 cycles with start pulses
    load(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000);
    run_frame(2'b01, 2'b11, 0, 0, 5, 1, 32'h40800000, 5'b0);

    // reset after 2 of 4 samples
    load(32'h41200000, 32'h41A00000, 32'h3F800000, 32'h3F800000, 4'b0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = f_smp[i]; in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_out_data", 64'(out_data), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_state", 64'(dbg_state), 64'(0));
    check("abort_add_a", 64'(add_a), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    load(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000);
    run_frame(2'b00, 2'b00, 0, 0, 0, 1, 32'h40800000, 5'b0);

    // randomized frames
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < NT; i++) begin
        f_smp[i] = {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
        f_sub[i] = 1'($urandom);
      end
      run_frame(2'($urandom), 2'($urandom), 0, 2, $urandom_range(3, 0), 0, 32'h0, 5'h0);
    end

    to = 0;
    while (exp_q.size() != 0 && to < 100) begin @(posedge clk); to++; end
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
